// File: rtl/jump_ctrl.sv
// jump_ctrl: redirect arbitration, flush/wait sequencing, pipeline hold merge and redirect counting
module jump_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  jump_enable_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                  int_assert_i,
    input  logic [ADDR_WIDTH-1:0] int_addr_i,
    input  logic                  hold_ex_i,
    input  logic                  hold_bus_i,
    input  logic                  hold_jtag_i,
    output logic                  pc_load_o,
    output logic [ADDR_WIDTH-1:0] pc_load_addr_o,
    output logic                  flush_o,
    output logic                  hold_pc_o,
    output logic                  hold_id_o,
    output logic [31:0]           redirect_cnt_o
);
    typedef enum logic [1:0] {RUN, FLUSH, WAIT} state_t;
    localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam state_t ACC_STATE = FLUSH_CYCLES > 1 ? FLUSH : RUN;
    state_t state;
    logic [2:0] flush_cnt;
    logic [ADDR_WIDTH-1:0] pend_addr, tgt, load_addr;
    logic [31:0] redirect_cnt;
    logic req, load, stall;
    always_comb begin
        req       = int_assert_i | (jump_enable_i & state == RUN);
        tgt       = int_assert_i ? int_addr_i : jump_addr_i;
        load      = state == WAIT ? !hold_bus_i : req & !hold_bus_i;
        load_addr = state == WAIT & !int_assert_i ? pend_addr : tgt;
        stall     = hold_ex_i | hold_bus_i | hold_jtag_i;
    end
    assign pc_load_o      = rst_i & load;
    assign pc_load_addr_o = pc_load_o ? load_addr : '0;
    assign flush_o        = rst_i & (state != RUN | req);
    assign hold_id_o      = rst_i & stall;
    assign hold_pc_o      = rst_i & !load & (stall | state == WAIT);
    assign redirect_cnt_o = redirect_cnt;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= RUN;
            flush_cnt    <= '0;
            pend_addr    <= '0;
            redirect_cnt <= '0;
        end else begin
            redirect_cnt <= redirect_cnt + 32'(load);
            if (load) begin
                state     <= ACC_STATE;
                flush_cnt <= RELOAD;
            end else if (req & state != WAIT) begin
                pend_addr <= tgt;
                state     <= WAIT;
            end else if (state == WAIT & int_assert_i) begin
                pend_addr <= int_addr_i;
            end else if (state == FLUSH & !hold_bus_i) begin
                flush_cnt <= flush_cnt - 3'd1;
                if (flush_cnt == 3'd1) state <= RUN;
            end
        end
    end
endmodule
